// File: rtl/construtor_caminho.sv
// Path construction: walks the predecessor memory from destination back to source,
// stacks the nodes, then streams the path source-first over a valid/ready interface.
module construtor_caminho #(
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_PATH   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          construir_in,
  input  logic [ADDR_WIDTH-1:0]         fonte_in,
  input  logic [ADDR_WIDTH-1:0]         destino_in,
  output logic                          pai_rd_out,
  output logic [ADDR_WIDTH-1:0]         pai_addr_out,
  input  logic [ADDR_WIDTH-1:0]         pai_data_in,
  input  logic                          pai_valido_in,
  output logic                          caminho_pronto_out,
  output logic                          erro_out,
  output logic [$clog2(MAX_PATH+1)-1:0] tamanho_out,
  output logic                          no_valid_out,
  output logic [ADDR_WIDTH-1:0]         no_out,
  output logic                          no_ultimo_out,
  input  logic                          no_ready_in,
  input  logic                          lido_in
);

  localparam int SPW = $clog2(MAX_PATH + 1);
  localparam int IW  = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1;
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);
  localparam logic [SPW-1:0] SP_MAX = SPW'(MAX_PATH);

  typedef enum logic [2:0] {IDLE, LER, ESPERA, PRONTO, ERRO} estado_t;

  estado_t               state_reg, state_next;
  logic [ADDR_WIDTH-1:0] atual_reg, atual_next;
  logic [ADDR_WIDTH-1:0] fonte_reg, fonte_next;
  logic [SPW-1:0]        sp_reg, sp_next;
  logic [SPW-1:0]        tamanho_reg, tamanho_next;

  logic [ADDR_WIDTH-1:0] pilha [MAX_PATH];
  logic                  push_en;
  logic [IW-1:0]         push_idx;
  logic [ADDR_WIDTH-1:0] push_data;
  logic [IW-1:0]         top_idx;

  assign top_idx     = IW'(sp_reg - SP_ONE);
  assign tamanho_out = tamanho_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      atual_reg   <= '0;
      fonte_reg   <= '0;
      sp_reg      <= '0;
      tamanho_reg <= '0;
    end else begin
      state_reg   <= state_next;
      atual_reg   <= atual_next;
      fonte_reg   <= fonte_next;
      sp_reg      <= sp_next;
      tamanho_reg <= tamanho_next;
    end
  end

  // Stack storage carries no reset; reads are gated by sp so stale entries never escape.
  always_ff @(posedge clk) begin
    if (push_en)
      pilha[push_idx] <= push_data;
  end

  always_comb begin
    state_next         = state_reg;
    atual_next         = atual_reg;
    fonte_next         = fonte_reg;
    sp_next            = sp_reg;
    tamanho_next       = tamanho_reg;
    push_en            = 1'b0;
    push_idx           = sp_reg[IW-1:0];
    push_data          = pai_data_in;
    pai_rd_out         = 1'b0;
    pai_addr_out       = '0;
    caminho_pronto_out = 1'b0;
    erro_out           = 1'b0;
    no_valid_out       = 1'b0;
    no_out             = '0;
    no_ultimo_out      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (construir_in) begin
          fonte_next   = fonte_in;
          atual_next   = destino_in;
          push_en      = 1'b1;
          push_idx     = '0;
          push_data    = destino_in;
          sp_next      = SP_ONE;
          tamanho_next = SP_ONE;
          state_next   = (destino_in == fonte_in) ? PRONTO : LER;
        end
      end

      LER: begin
        pai_rd_out   = 1'b1;
        pai_addr_out = atual_reg;
        if (!construir_in) begin
          state_next   = IDLE;
          sp_next      = '0;
          tamanho_next = '0;
        end else begin
          state_next = ESPERA;
        end
      end

      ESPERA: begin
        if (!construir_in) begin
          state_next   = IDLE;
          sp_next      = '0;
          tamanho_next = '0;
        end else if (!pai_valido_in || sp_reg == SP_MAX) begin
          // Missing predecessor or full stack; a cyclic chain ends up here too.
          state_next   = ERRO;
          tamanho_next = '0;
        end else begin
          push_en      = 1'b1;
          atual_next   = pai_data_in;
          sp_next      = sp_reg + SP_ONE;
          tamanho_next = tamanho_reg + SP_ONE;
          state_next   = (pai_data_in == fonte_reg) ? PRONTO : LER;
        end
      end

      PRONTO: begin
        caminho_pronto_out = 1'b1;
        no_valid_out       = (sp_reg != '0);
        no_ultimo_out      = (sp_reg == SP_ONE);
        if (sp_reg != '0)
          no_out = pilha[top_idx];
        // Release beats a simultaneous pop: the stack is discarded either way.
        if (lido_in) begin
          state_next   = IDLE;
          sp_next      = '0;
          tamanho_next = '0;
        end else if ((sp_reg != '0) && no_ready_in) begin
          sp_next = sp_reg - SP_ONE;
        end
      end

      ERRO: begin
        caminho_pronto_out = 1'b1;
        erro_out           = 1'b1;
        if (lido_in) begin
          state_next   = IDLE;
          sp_next      = '0;
          tamanho_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
        sp_next    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_construtor_caminho.sv
// Randomized and directed bench for construtor_caminho; a queue-based path model
// derives read addresses, completion cycle, size and stream order for every build.
module tb_construtor_caminho;
  localparam int AW = 4;
  localparam int MP = 4;
  localparam int TW = $clog2(MP + 1);

  logic          clk;
  logic          rst_n;
  logic          construir_in;
  logic [AW-1:0] fonte_in, destino_in;
  logic          pai_rd_out;
  logic [AW-1:0] pai_addr_out;
  logic [AW-1:0] pai_data_in;
  logic          pai_valido_in;
  logic          caminho_pronto_out, erro_out;
  logic [TW-1:0] tamanho_out;
  logic          no_valid_out;
  logic [AW-1:0] no_out;
  logic          no_ultimo_out;
  logic          no_ready_in, lido_in;

  construtor_caminho #(.ADDR_WIDTH(AW), .MAX_PATH(MP)) dut (
    .clk(clk), .rst_n(rst_n), .construir_in(construir_in),
    .fonte_in(fonte_in), .destino_in(destino_in),
    .pai_rd_out(pai_rd_out), .pai_addr_out(pai_addr_out),
    .pai_data_in(pai_data_in), .pai_valido_in(pai_valido_in),
    .caminho_pronto_out(caminho_pronto_out), .erro_out(erro_out),
    .tamanho_out(tamanho_out), .no_valid_out(no_valid_out),
    .no_out(no_out), .no_ultimo_out(no_ultimo_out),
    .no_ready_in(no_ready_in), .lido_in(lido_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] pai_mem [16];
  bit            pai_vld [16];

  // Predecessor memory: answers one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (pai_rd_out === 1'b1) begin
      pai_data_in   <= pai_mem[pai_addr_out];
      pai_valido_in <= pai_vld[pai_addr_out];
    end else begin
      pai_data_in   <= AW'($urandom);
      pai_valido_in <= 1'($urandom);
    end
  end

  int tests = 0;
  int fails = 0;
  int obs_pronto;
  int obs_tam;
  int obs_stream[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_pronto"}, caminho_pronto_out, 0);
    chk({name, "_erro"}, erro_out, 0);
    chk({name, "_tam"}, tamanho_out, 0);
    chk({name, "_valid"}, no_valid_out, 0);
    chk({name, "_no"}, no_out, 0);
    chk({name, "_ultimo"}, no_ultimo_out, 0);
    chk({name, "_rd"}, pai_rd_out, 0);
    chk({name, "_addr"}, pai_addr_out, 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      pai_mem[i] = '0;
      pai_vld[i] = 1'b0;
    end
  endtask

  // Walk the chain: nodes[] is destination-first, reads = memory accesses made.
  task automatic model(input int src, input int dst, output int nodes[$], output bit err,
                       output int reads);
    int n;
    nodes.delete();
    nodes.push_back(dst);
    err   = 1'b0;
    reads = 0;
    if (src != dst) begin
      while (1) begin
        reads++;
        n = nodes[nodes.size() - 1];
        if (!pai_vld[n]) begin err = 1'b1; break; end
        if (nodes.size() == MP) begin err = 1'b1; break; end
        nodes.push_back(int'(pai_mem[n]));
        if (int'(pai_mem[n]) == src) break;
      end
    end
  endtask

  task automatic run_build(input int src, input int dst, input int rmode, input int abort_at,
                           input int lido_at, input bit rst_pronto);
    int nodes[$];
    int sexp[$];
    bit err;
    int reads, pr, n, idx, guard, k;
    bit rdy;
    int pat[7] = '{0, 1, 0, 0, 1, 1, 1};
    model(src, dst, nodes, err, reads);
    pr = 1 + 2 * reads;
    obs_pronto = -1;
    obs_tam    = -1;
    obs_stream.delete();
    @(negedge clk);
    fonte_in     = AW'(src);
    destino_in   = AW'(dst);
    construir_in = 1'b1;
    no_ready_in  = 1'b0;
    lido_in      = 1'b0;
    for (int c = 1; c <= pr; c++) begin
      @(negedge clk);
      if (caminho_pronto_out === 1'b1 && obs_pronto < 0) obs_pronto = c;
      if (c < pr) begin
        chk("build_pronto", caminho_pronto_out, 0);
        chk("build_rd", pai_rd_out, c % 2);
        if (c % 2 == 1) chk("build_addr", pai_addr_out, nodes[(c - 1) / 2]);
        if (c == abort_at) begin
          construir_in = 1'b0;
          repeat (3) begin
            @(negedge clk);
            chk("abort_pronto", caminho_pronto_out, 0);
            chk("abort_rd", pai_rd_out, 0);
            chk("abort_tam", tamanho_out, 0);
          end
          return;
        end
      end else begin
        chk("done_pronto", caminho_pronto_out, 1);
        chk("done_erro", erro_out, err);
        chk("done_tam", tamanho_out, err ? 0 : nodes.size());
        chk("done_valid", no_valid_out, !err);
        chk("done_rd", pai_rd_out, 0);
        obs_tam = int'(tamanho_out);
      end
    end

    if (rst_pronto) begin
      rst_n = 1'b0;
      #1;
      check_idle("async_rst");
      @(negedge clk);
      construir_in = 1'b0;
      rst_n = 1'b1;
      return;
    end

    if (err) begin
      @(negedge clk);
      chk("erro_hold", erro_out, 1);
      chk("erro_pronto_hold", caminho_pronto_out, 1);
      chk("erro_valid", no_valid_out, 0);
      chk("erro_tam", tamanho_out, 0);
    end else begin
      for (int i = nodes.size() - 1; i >= 0; i--) sexp.push_back(nodes[i]);
      n = sexp.size();
      idx = 0;
      guard = 0;
      k = 0;
      while (idx < n && guard < 60) begin
        chk("stream_valid", no_valid_out, 1);
        chk("stream_node", no_out, sexp[idx]);
        chk("stream_ultimo", no_ultimo_out, idx == n - 1);
        chk("stream_tam", tamanho_out, n);
        chk("stream_pronto", caminho_pronto_out, 1);
        if (idx == lido_at) begin
          no_ready_in  = 1'b1;
          lido_in      = 1'b1;
          construir_in = 1'b0;
          @(negedge clk);
          lido_in     = 1'b0;
          no_ready_in = 1'b0;
          check_idle("lido_pop");
          return;
        end
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = (k < 7) ? pat[k] != 0 : 1'b1;
          default: rdy = 1'($urandom);
        endcase
        no_ready_in = rdy;
        if (rdy) obs_stream.push_back(int'(no_out));
        @(negedge clk);
        guard++;
        k++;
        if (rdy) idx++;
      end
      if (idx < n) chk("stream_timeout", idx, n);
      no_ready_in = 1'($urandom);
      chk("drained_valid", no_valid_out, 0);
      chk("drained_pronto", caminho_pronto_out, 1);
    end

    lido_in      = 1'b1;
    construir_in = 1'b0;
    @(negedge clk);
    lido_in     = 1'b0;
    no_ready_in = 1'b0;
    check_idle("lido");
  endtask

  task automatic check_lit_stream(input string name, input int e0, input int e1,
                                  input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({name, "_len"}, obs_stream.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < obs_stream.size()) chk({name, "_node"}, obs_stream[i], e[i]);
  endtask

  task automatic set_chain4();
    clear_mem();
    pai_mem[9] = 4'd5; pai_vld[9] = 1'b1;
    pai_mem[5] = 4'd2; pai_vld[5] = 1'b1;
    pai_mem[2] = 4'd0; pai_vld[2] = 1'b1;
  endtask

  initial begin
    int perm[16];
    int len, j, tmp, src, dst;
    rst_n = 1'b0;
    construir_in = 1'b0;
    fonte_in = '0;
    destino_in = '0;
    no_ready_in = 1'b0;
    lido_in = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // Source equals destination.
    run_build(3, 3, 0, 0, -1, 1'b0);
    chk("lit_same_pronto", obs_pronto, 1);
    chk("lit_same_tam", obs_tam, 1);
    chk("lit_same_len", obs_stream.size(), 1);
    if (obs_stream.size() > 0) chk("lit_same_node", obs_stream[0], 3);

    // Four-node chain, full speed then back-pressure.
    set_chain4();
    run_build(0, 9, 0, 0, -1, 1'b0);
    chk("lit_chain_pronto", obs_pronto, 7);
    chk("lit_chain_tam", obs_tam, 4);
    check_lit_stream("lit_chain", 0, 2, 5, 9);
    run_build(0, 9, 1, 0, -1, 1'b0);
    check_lit_stream("lit_bp", 0, 2, 5, 9);

    // Missing predecessor for node 5.
    pai_vld[5] = 1'b0;
    run_build(0, 9, 0, 0, -1, 1'b0);
    chk("lit_miss_pronto", obs_pronto, 5);
    chk("lit_miss_tam", obs_tam, 0);

    // Five-node chain overflows a four-deep stack.
    set_chain4();
    pai_mem[11] = 4'd9; pai_vld[11] = 1'b1;
    run_build(0, 11, 0, 0, -1, 1'b0);
    chk("lit_ovf_pronto", obs_pronto, 9);
    chk("lit_ovf_tam", obs_tam, 0);

    // Self loop.
    pai_mem[7] = 4'd7; pai_vld[7] = 1'b1;
    run_build(0, 7, 0, 0, -1, 1'b0);
    chk("lit_loop_pronto", obs_pronto, 9);

    // Abort during ESPERA, then a clean rebuild.
    set_chain4();
    run_build(0, 9, 0, 2, -1, 1'b0);
    run_build(0, 9, 0, 0, -1, 1'b0);
    check_lit_stream("lit_after_abort", 0, 2, 5, 9);

    // Release coinciding with a pop, then reset during PRONTO.
    run_build(0, 9, 0, 0, 1, 1'b0);
    run_build(0, 9, 0, 0, -1, 1'b1);
    @(negedge clk);
    check_idle("post_rst");
    run_build(0, 9, 2, 0, -1, 1'b0);
    check_lit_stream("lit_after_rst", 0, 2, 5, 9);

    // Random graphs: half with a planted simple path, half fully random.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++) begin
        pai_mem[i] = AW'($urandom);
        pai_vld[i] = ($urandom_range(0, 7) != 0);
        perm[i] = i;
      end
      for (int i = 15; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      if (it % 2 == 0) begin
        len = $urandom_range(1, 6);
        for (int i = 0; i < len - 1; i++) begin
          pai_mem[perm[i]] = AW'(perm[i + 1]);
          pai_vld[perm[i]] = 1'b1;
        end
        dst = perm[0];
        src = perm[len - 1];
      end else begin
        dst = $urandom_range(0, 15);
        src = $urandom_range(0, 15);
      end
      run_build(src, dst, 2, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0,
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/construtor_caminho.md
# construtor_caminho

Path-construction stage driven by the top-level state controller. While `construir_in` is high, it walks the predecessor memory from destination back to source and pushes each node onto an internal stack. It then reports `caminho_pronto_out` and streams the path source-first over a valid/ready interface until `lido_in` returns it to idle. Invalid or overlong chains are flagged with `erro_out`.

## Interface
- `ADDR_WIDTH`, default 6: node identifier width; predecessor memory address and data width.
- `MAX_PATH`, default 64: stack depth, i.e. the maximum number of nodes in a path, source and destination included.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `construir_in`  in  1  build request, level; held high by the controller during its path-construction state.
- `fonte_in`  in  ADDR_WIDTH  source node; sampled when a build starts.
- `destino_in`  in  ADDR_WIDTH  destination node; sampled when a build starts.
- `pai_rd_out`  out  1  predecessor memory read strobe.
- `pai_addr_out`  out  ADDR_WIDTH  predecessor memory read address.
- `pai_data_in`  in  ADDR_WIDTH  predecessor of the addressed node; valid 1 cycle after `pai_rd_out`.
- `pai_valido_in`  in  1  addressed node has a recorded predecessor; same timing as `pai_data_in`.
- `caminho_pronto_out`  out  1  build finished, successfully or with error.
- `erro_out`  out  1  build failed: missing predecessor or stack overflow.
- `tamanho_out`  out  $clog2(MAX_PATH+1)  node count of the built path; 0 on error.
- `no_valid_out`  out  1  `no_out` holds a path node.
- `no_out`  out  ADDR_WIDTH  path node, source first.
- `no_ultimo_out`  out  1  current node is the destination, the last node of the stream.
- `no_ready_in`  in  1  consumer accepts `no_out`.
- `lido_in`  in  1  result consumed; return to idle.

## Operation
- States: IDLE, LER, ESPERA, PRONTO, ERRO.
- Registers: `atual` (current node), `fonte` (latched source), stack pointer `sp` of width $clog2(MAX_PATH+1), and stack `pilha[MAX_PATH]`.
- **IDLE:**
  - When `construir_in` = 1: latch `fonte_in`, set `pilha[0]` = `destino_in`, `atual` = `destino_in`, `sp` = 1, `tamanho_out` = 1.
  - Then go to PRONTO if `destino_in` == `fonte_in`; otherwise go to LER.
- **LER:** `pai_rd_out` = 1, `pai_addr_out` = `atual`; go to ESPERA.
- **ESPERA:** checks are evaluated in this order:
  - `pai_valido_in` = 0 → ERRO.
  - else `sp` == MAX_PATH → ERRO (overflow).
  - else push `pai_data_in`, set `atual` = `pai_data_in`, increment `sp` and `tamanho_out`; go to PRONTO if `pai_data_in` == `fonte`, otherwise go to LER.
- **Abort:** `construir_in` = 0 while in LER or ESPERA → IDLE with `sp` = 0; no `caminho_pronto_out` pulse.
- **PRONTO:**
  - `caminho_pronto_out` = 1.
  - `no_valid_out` = (`sp` != 0), `no_out` = `pilha[sp-1]`, `no_ultimo_out` = (`sp` == 1).
  - On `no_valid_out` && `no_ready_in`, decrement `sp` (pop).
  - `tamanho_out` holds the built count while the stream drains.
  - `lido_in` → IDLE.
- **ERRO:**
  - `caminho_pronto_out` = 1, `erro_out` = 1, `tamanho_out` = 0, `no_valid_out` = 0.
  - `lido_in` → IDLE.
- `construir_in` is ignored in PRONTO and ERRO. `lido_in` is ignored in IDLE, LER and ESPERA.
- `lido_in` arriving in the same cycle as a stream handshake: `lido_in` wins, the pop is discarded, and `sp` goes to 0.
- A path of exactly MAX_PATH nodes succeeds; MAX_PATH+1 nodes gives ERRO.
- Cycles in the predecessor chain end in overflow ERRO; no separate detection.

## Timing
- **Reset:** all outputs 0, `pai_addr_out` = 0, state IDLE, `sp` = 0, `atual` = 0.
- **Build latency:** with the build start counted as cycle 0:
  - `caminho_pronto_out` rises at cycle 1 + 2·(N−1) for an N-node path.
  - N = 1: PRONTO at cycle 1.
- **Memory read:** exactly one `pai_rd_out` pulse per hop, 2 cycles per hop. Data is sampled in the cycle after the strobe; no back-pressure on the memory.
- **Stream:**
  - `no_valid_out` is high from the first PRONTO cycle.
  - Up to one node per cycle.
  - `no_out` is stable while `no_valid_out` && !`no_ready_in`.
  - After the last pop, `no_valid_out` = 0 and `caminho_pronto_out` stays 1 until `lido_in`.
- **Return to idle:** `lido_in` sampled high → outputs clear in the next cycle (IDLE).
- **Asynchronous reset mid-operation:** immediately returns to the reset state from any state.

## Test plan
- **Source equals destination:** `fonte_in` = `destino_in` = 3, `construir_in` = 1 → `caminho_pronto_out` at cycle 1, `tamanho_out` = 1, stream emits 3 with `no_ultimo_out` = 1, no `pai_rd_out` pulses.
- **Four-node chain:** memory pai[9]=5, pai[5]=2, pai[2]=0; fonte = 0, destino = 9 → reads at addresses 9, 5, 2; `caminho_pronto_out` at cycle 7, `tamanho_out` = 4; with `no_ready_in` = 1 the stream is 0, 2, 5, 9 and `no_ultimo_out` is high only on 9.
- **Back-pressure:** same chain with `no_ready_in` pattern 0,1,0,0,1,1,1 → each node is held stable until accepted; order is unchanged.
- **Missing predecessor:** `pai_valido_in` = 0 for node 5 → `erro_out` = 1, `caminho_pronto_out` = 1, `tamanho_out` = 0, `no_valid_out` = 0; `lido_in` → IDLE next cycle.
- **Overflow boundary (MAX_PATH = 4):**
  - 4-node chain → success, `tamanho_out` = 4.
  - 5-node chain → ERRO after the 4th push attempt.
  - Self-loop pai[7]=7 → ERRO.
- **Abort and reset:**
  - `construir_in` dropped during ESPERA → IDLE, no `caminho_pronto_out`, then a new build runs correctly.
  - `rst_n` asserted during PRONTO → all outputs 0 immediately.
